// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready pipeline stage with a skid slot so that in_ready is a flop output.
// Optional SKID_STALL_CNT_EN adds a saturating count of output-stall cycles on stall_cnt.
module pipe_skid_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SKID_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_q, main_nxt;
  logic [WIDTH-1:0] skid_q, skid_nxt;
  logic             in_fire, out_fire;

  always_comb begin
    out_valid = (state != EMPTY);
    in_fire   = in_valid & in_ready;
    out_fire  = out_valid & out_ready;
    out_data  = main_q;
  end

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      // Held words are only invalidated; their data registers are left as-is.
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = BUSY;
            main_nxt  = in_data;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_nxt = in_data;
          end else if (in_fire) begin
            state_nxt = FULL;
            skid_nxt  = in_data;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_nxt = BUSY;
            main_nxt  = skid_q;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state    <= EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      main_q   <= main_nxt;
      skid_q   <= skid_nxt;
      in_ready <= (state_nxt != FULL);
    end
  end

`ifdef SKID_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: stimulus pushes accepted words, a negedge monitor pops on output fire.
// Stall-counter checks are compiled only with SKID_STALL_CNT_EN.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        clr_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
`ifdef SKID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] exp_q[$];

  pipe_skid_reg #(.WIDTH(32)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SKID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs change only just after a rising edge, so in_ready read here is the value the next edge uses.
  task automatic drive(input logic v, input logic [31:0] d, output bit pushed);
    in_valid = v;
    in_data  = d;
    pushed   = v && in_ready && clr_n && !flush;
    if (pushed) exp_q.push_back(d);
  endtask

  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_clr = 1'b0, prev_flush = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (prev_valid && !prev_ready && prev_clr && !prev_flush) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", out_data, prev_data);
    end
    if (out_valid && out_ready && clr_n) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got 0x%0h expected no word", out_data);
      end else begin
        check("out_word", out_data, exp_q.pop_front());
      end
    end
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_clr   = clr_n;
    prev_flush = flush;
    prev_data  = out_data;
  end

  initial begin
    bit          p;
    bit          sent;
    logic [31:0] words[3];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;

    clr_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef SKID_STALL_CNT_EN
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    clr_n = 1'b1;
    step();
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b1, words[i], p);
      step();
      check("stream_latency_valid", {31'd0, out_valid}, 32'd1);
      check("stream_latency_data", out_data, words[i]);
    end
    drive(1'b0, '0, p);
    step();
    check("stream_empty", {31'd0, out_valid}, 32'd0);

    // Backpressure into FULL, then drain
    out_ready = 1'b0;
    drive(1'b1, 32'hA1, p); step();
    drive(1'b1, 32'hA2, p); step();
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_out_data", out_data, 32'hA1);
    drive(1'b1, 32'hA3, p); step();
    drive(1'b1, 32'hA3, p); step();
    check("full_hold_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_hold_data", out_data, 32'hA1);
    out_ready = 1'b1;
    sent = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!sent) begin
        drive(1'b1, 32'hA3, p);
        sent = p;
      end else begin
        drive(1'b0, '0, p);
      end
      step();
    end
    check("a3_accepted", {31'd0, sent}, 32'd1);
    step();
    check("drain_empty_q", exp_q.size(), 32'd0);

    // Simultaneous input and output fire in BUSY
    drive(1'b1, 32'h5, p); step();
    drive(1'b1, 32'h6, p); step();
    check("sim_out_data", out_data, 32'h6);
    check("sim_in_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b0, '0, p); step();
    check("sim_empty", {31'd0, out_valid}, 32'd0);

    // Flush while FULL; B3 offered during flush must never appear
    out_ready = 1'b0;
    drive(1'b1, 32'hB1, p); step();
    drive(1'b1, 32'hB2, p); step();
    flush = 1'b1;
    drive(1'b1, 32'hB3, p);
    step();
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    flush = 1'b0;
    exp_q.delete();
    drive(1'b0, '0, p);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 32'hE1, p); step();
    drive(1'b1, 32'hE2, p); step();
    clr_n = 1'b0;
    drive(1'b0, '0, p);
    step();
    check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_out_data", out_data, 32'd0);
    check("mrst_in_ready", {31'd0, in_ready}, 32'd0);
    exp_q.delete();
    clr_n = 1'b1;
    step();
    check("mrst_rel_in_ready", {31'd0, in_ready}, 32'd1);

`ifdef SKID_STALL_CNT_EN
    check("cnt_after_rst", {16'd0, stall_cnt}, 32'd0);
    drive(1'b1, 32'hC1, p); step();
    drive(1'b0, '0, p);
    for (int i = 0; i < 5; i++) step();
    check("cnt_five", {16'd0, stall_cnt}, 32'd5);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_q.delete();
    check("cnt_after_flush", {16'd0, stall_cnt}, 32'd5);
    out_ready = 1'b0;
    drive(1'b1, 32'hD1, p); step();
    drive(1'b0, '0, p);
    for (int i = 0; i < 65529; i++) step();
    check("cnt_fffe", {16'd0, stall_cnt}, 32'hFFFE);
    for (int i = 0; i < 3; i++) step();
    check("cnt_sat", {16'd0, stall_cnt}, 32'hFFFF);
    out_ready = 1'b1;
    step(); step();
`endif

    check("final_empty_q", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
